// File: rtl/uart_cmd_master_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_master_if
//
// Command / read-result bus between a host and uart_cmd_master.
//
// Signals:
//   cmd_in  [15:0] : [15] write flag, [14:8] address, [7:0] write data
//   cmd_vld        : command valid (host -> master)
//   cmd_rdy        : master idle, ready to accept a command
//   rd_data [7:0]  : last successfully received read byte
//   rd_vld         : one-cycle read-complete strobe
//   rd_err         : one-cycle read error strobe (parity, stop or timeout)
//   busy           : transaction in progress (inverse of cmd_rdy)
//
// Modports:
//   master : the host side (drives commands, observes results)
//   slave  : the uart_cmd_master side
// -----------------------------------------------------------------------------
interface uart_cmd_master_if;
  logic [15:0] cmd_in;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [7:0]  rd_data;
  logic        rd_vld;
  logic        rd_err;
  logic        busy;

  modport master (
    output cmd_in,
    output cmd_vld,
    input  cmd_rdy,
    input  rd_data,
    input  rd_vld,
    input  rd_err,
    input  busy
  );

  modport slave (
    input  cmd_in,
    input  cmd_vld,
    output cmd_rdy,
    output rd_data,
    output rd_vld,
    output rd_err,
    output busy
  );
endinterface

// File: rtl/uart_cmd_master.sv
// -----------------------------------------------------------------------------
// uart_cmd_master
//
// Turns 16-bit host commands into UART transactions on a single tx/rx pair.
//   Write (cmd[15]=1): frame {cmd[15:8]}, GAP_BITS idle bit-times, frame cmd[7:0].
//   Read  (cmd[15]=0): frame {cmd[15:8]}, then wait up to RX_TIMEOUT bit-times
//                      for a reply frame on rx; result reported via rd_vld/rd_err.
// Frame format: start 0, 8 data bits LSB first, optional even parity, stop 1.
//
// Build option:
//   UART_PARITY_EN : when defined, an even-parity bit follows the data bits on
//                    both directions and a parity mismatch on receive gives
//                    rd_err. When undefined, frames are 10 bits.
//
// Parameters:
//   CLK_DIV    : clk cycles per UART bit (4..65535)
//   GAP_BITS   : idle bit-times between the two frames of a write
//   RX_TIMEOUT : bit-times allowed from the end of the read request to the
//                reply start bit
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset; aborts any transaction, tx high
//   bus   : command / result bus (uart_cmd_master_if.slave)
//   rx    : serial input, asynchronous to clk
//   tx    : serial output, idle high
// -----------------------------------------------------------------------------
module uart_cmd_master #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned GAP_BITS   = 2,
  parameter int unsigned RX_TIMEOUT = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uart_cmd_master_if.slave        bus,
  input  logic                    rx,
  output logic                    tx
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    TX_START = 4'd1,
    TX_DATA  = 4'd2,
    TX_PAR   = 4'd3,
    TX_STOP  = 4'd4,
    GAP      = 4'd5,
    RX_WAIT  = 4'd6,
    RX_START = 4'd7,
    RX_DATA  = 4'd8,
    RX_PAR   = 4'd9,
    RX_STOP  = 4'd10,
    DONE     = 4'd11
  } state_t;

`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  // Last count of one bit-time, and the mid-bit point used to confirm a start bit.
  localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 32'd1);
  localparam logic [15:0] BIT_HALF = 16'(CLK_DIV / 32'd2);
  // Long-interval end counts; GAP_LAST is only consulted when GAP_BITS is non-zero.
  localparam logic [31:0] GAP_LAST = 32'(GAP_BITS * CLK_DIV - 32'd1);
  localparam logic [31:0] TO_LAST  = 32'(RX_TIMEOUT * CLK_DIV - 32'd1);

  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  state_t      state_q,    state_d;
  logic [15:0] bit_cnt_q,  bit_cnt_d;
  logic [2:0]  bit_idx_q,  bit_idx_d;
  logic [31:0] long_cnt_q, long_cnt_d;
  logic        wr_q,       wr_d;
  logic        second_q,   second_d;
  logic [7:0]  wdata_q,    wdata_d;
  logic [7:0]  tx_byte_q,  tx_byte_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        par_ok_q,   par_ok_d;
  logic        tx_q,       tx_d;
  logic        cmd_rdy_q,  cmd_rdy_d;
  logic        busy_q,     busy_d;
  logic [7:0]  rd_data_q,  rd_data_d;
  logic        rd_vld_q,   rd_vld_d;
  logic        rd_err_q,   rd_err_d;
  logic        rx_meta_q,  rx_meta_d;
  logic        rx_sync_q,  rx_sync_d;
  logic        rx_prev_q,  rx_prev_d;

  logic        bit_end_s;
  logic        rx_fall_s;

  assign bit_end_s = (bit_cnt_q == BIT_LAST);
  // Falling edge seen on the synchronised rx (previous 1, current 0).
  assign rx_fall_s = rx_prev_q & ~rx_sync_q;

  assign tx          = tx_q;
  assign bus.cmd_rdy = cmd_rdy_q;
  assign bus.busy    = busy_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_vld  = rd_vld_q;
  assign bus.rd_err  = rd_err_q;

  // Next-state, counters, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    long_cnt_d = long_cnt_q;
    wr_d       = wr_q;
    second_d   = second_q;
    wdata_d    = wdata_q;
    tx_byte_d  = tx_byte_q;
    rx_shift_d = rx_shift_q;
    par_ok_d   = par_ok_q;
    rd_data_d  = rd_data_q;
    rd_vld_d   = 1'b0;
    rd_err_d   = 1'b0;
    rx_meta_d  = rx;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;

    case (state_q)
      IDLE: begin
        // cmd_rdy is high in IDLE, so cmd_vld alone means acceptance here.
        if (bus.cmd_vld) begin
          wr_d      = bus.cmd_in[15];
          wdata_d   = bus.cmd_in[7:0];
          tx_byte_d = bus.cmd_in[15:8];
          second_d  = 1'b0;
          par_ok_d  = 1'b1;
          bit_cnt_d = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = TX_START;
        end else begin
          state_d   = IDLE;
        end
      end

      TX_START: begin
        if (bit_end_s) begin
          bit_cnt_d = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = TX_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

      TX_DATA: begin
        if (bit_end_s) begin
          bit_cnt_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = PAR_EN ? TX_PAR : TX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

      TX_PAR: begin
        if (bit_end_s) begin
          bit_cnt_d = 16'd0;
          state_d   = TX_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

      TX_STOP: begin
        if (bit_end_s) begin
          bit_cnt_d  = 16'd0;
          long_cnt_d = 32'd0;
          if (second_q) begin
            state_d = DONE;
          end else if (wr_q) begin
            if (GAP_BITS == 32'd0) begin
              tx_byte_d = wdata_q;
              second_d  = 1'b1;
              bit_idx_d = 3'd0;
              state_d   = TX_START;
            end else begin
              state_d   = GAP;
            end
          end else begin
            state_d = RX_WAIT;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

      GAP: begin
        if (long_cnt_q == GAP_LAST) begin
          tx_byte_d = wdata_q;
          second_d  = 1'b1;
          bit_cnt_d = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = TX_START;
        end else begin
          long_cnt_d = long_cnt_q + 32'd1;
        end
      end

      RX_WAIT: begin
        // long_cnt holds its value across RX_START so a rejected glitch
        // costs nothing against the timeout.
        if (rx_fall_s) begin
          bit_cnt_d = 16'd0;
          state_d   = RX_START;
        end else if (long_cnt_q == TO_LAST) begin
          rd_err_d  = 1'b1;
          state_d   = DONE;
        end else begin
          long_cnt_d = long_cnt_q + 32'd1;
        end
      end

      RX_START: begin
        if (bit_cnt_q == BIT_HALF) begin
          bit_cnt_d = 16'd0;
          if (rx_sync_q) begin
            state_d   = RX_WAIT;
          end else begin
            bit_idx_d = 3'd0;
            state_d   = RX_DATA;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

      RX_DATA: begin
        // Counting from 0 after the mid-start sample puts each sample at
        // mid-bit, exactly CLK_DIV cycles after the previous one.
        if (bit_end_s) begin
          bit_cnt_d  = 16'd0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = PAR_EN ? RX_PAR : RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

      RX_PAR: begin
        if (bit_end_s) begin
          bit_cnt_d = 16'd0;
          par_ok_d  = (rx_sync_q == even_parity(rx_shift_q));
          state_d   = RX_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

      RX_STOP: begin
        if (bit_end_s) begin
          bit_cnt_d = 16'd0;
          state_d   = DONE;
          if (rx_sync_q && par_ok_q) begin
            rd_vld_d  = 1'b1;
            rd_data_d = rx_shift_q;
          end else begin
            rd_err_d  = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

      DONE: begin
        bit_cnt_d = 16'd0;
        state_d   = IDLE;
      end

      default: begin
        bit_cnt_d = 16'd0;
        state_d   = IDLE;
      end
    endcase

    // tx is registered from the next state so the line changes together
    // with the state register.
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_byte_d[bit_idx_d];
      TX_PAR:   tx_d = even_parity(tx_byte_d);
      default:  tx_d = 1'b1;
    endcase

    cmd_rdy_d = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
  end

  // State, datapath, output and rx-synchroniser registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 16'd0;
      bit_idx_q  <= 3'd0;
      long_cnt_q <= 32'd0;
      wr_q       <= 1'b0;
      second_q   <= 1'b0;
      wdata_q    <= 8'h00;
      tx_byte_q  <= 8'h00;
      rx_shift_q <= 8'h00;
      par_ok_q   <= 1'b1;
      tx_q       <= 1'b1;
      cmd_rdy_q  <= 1'b1;
      busy_q     <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_vld_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      long_cnt_q <= long_cnt_d;
      wr_q       <= wr_d;
      second_q   <= second_d;
      wdata_q    <= wdata_d;
      tx_byte_q  <= tx_byte_d;
      rx_shift_q <= rx_shift_d;
      par_ok_q   <= par_ok_d;
      tx_q       <= tx_d;
      cmd_rdy_q  <= cmd_rdy_d;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
      rd_vld_q   <= rd_vld_d;
      rd_err_q   <= rd_err_d;
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
    end
  end

endmodule
